serial_cmp_scheduler: RTL and testbench
=======================================

Name: serial_cmp_scheduler

Overview:
Two-requester scheduler and sequencer for a shared bit-serial magnitude comparator.
- Arbitrates round-robin between two parallel-operand requesters.
- Latches the granted operand pair and shifts it LSB-first through an internal serial compare accumulator, one bit per clock.
- Reports a registered eq/gt/lt result and a one-cycle completion pulse tagged with the requester ID.
- Sits between control logic that needs unsigned compares and the serial compare datapath, so many compares share one bit-serial comparator.

Parameters:
WIDTH, 8, operand width in bits (min 2); also the number of SHIFT cycles per compare.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset.
req0  in  1  requester 0 compare request (level).
a0  in  WIDTH  requester 0 operand A; sampled at the grant edge.
b0  in  WIDTH  requester 0 operand B; sampled at the grant edge.
req1  in  1  requester 1 compare request (level).
a1  in  WIDTH  requester 1 operand A.
b1  in  WIDTH  requester 1 operand B.
gnt0  out  1  one-cycle pulse: requester 0 operands accepted.
gnt1  out  1  one-cycle pulse: requester 1 operands accepted.
busy  out  1  high while in SHIFT or DONE.
done  out  1  one-cycle pulse: result valid.
done_id  out  1  requester that owns the current result (0 or 1).
res_eq  out  1  A == B (unsigned).
res_gt  out  1  A > B (unsigned).
res_lt  out  1  A < B (unsigned).

Behaviour:
Interface:
- reset is asynchronous, active-low; clock is clk.
- All outputs are registered.

Reset values:
- State = IDLE.
- gnt0=0, gnt1=0, busy=0, done=0, done_id=0.
- res_eq=1, res_gt=0, res_lt=0.
- RR pointer last=1, so requester 0 wins the first tie.
- Shift registers, bit counter and accumulator are cleared.

States:
- IDLE:
  - At an edge where req0 or req1 is high, arbitrate, latch the winner's A/B into shift registers, set the accumulator to eq=1/gt=0/lt=0, set cnt=0, and go to SHIFT.
  - The matching gnt is high for exactly the first SHIFT cycle.
- SHIFT, at each edge, with abit=sa[0] and bbit=sb[0]:
  - If abit > bbit: eq=0, gt=1, lt=0.
  - If abit < bbit: eq=0, gt=0, lt=1.
  - If the bits are equal: the accumulator holds.
  - Shift sa and sb right by one; cnt++.
  - At the edge processing cnt==WIDTH-1, copy the final accumulator (including that bit's update) to res_* and set done_id, then go to DONE.
  - The last differing bit processed (the most significant differing bit) decides the result, giving a true unsigned compare.
  - Exactly one of res_eq/res_gt/res_lt is high at all times.
- DONE (one cycle):
  - done=1.
  - Arbitrates exactly as IDLE: with a pending req, go straight to SHIFT (back-to-back); otherwise go to IDLE.

Timing and result hold:
- Latency: req sampled at edge 0, gnt in cycle 1, done in cycle WIDTH+1.
- Back-to-back throughput is one compare per WIDTH+1 cycles.
- res_* and done_id hold until the next DONE entry; they are not cleared at IDLE.

Arbitration:
- Only one request high: that requester is granted.
- Both high: grant the requester != last; last updates to the winner on every grant.
- A requester holding req high after its grant is re-served at the next arbitration point, subject to RR.
- req is ignored during SHIFT; no queueing beyond the level request.
- Operands are sampled only at the grant edge; later changes to a*/b* have no effect.

Reset mid-operation:
- Asserting reset in any state immediately forces the reset values; the in-flight compare is discarded with no done.
- After release, arbitration restarts from IDLE with last=1.

Test Plan:
1. WIDTH=8. req0=1 for one cycle, a0=0x5A, b0=0x5A -> gnt0 pulse in cycle 1; done in cycle 9 with done_id=0, res_eq=1, res_gt=0, res_lt=0; busy high in cycles 1-9.
2. req0, a0=0x80, b0=0x7F -> res_gt=1. Bits 0-6 set lt, then the MSB overrides it.
3. req1 only, a1=0x01, b1=0x02 -> gnt1; res_lt=1, done_id=1.
4. req0 and req1 both held high continuously, operands (0x10,0x20) and (0x30,0x30) -> grants alternate 0,1,0,1 starting with 0; done pulses every 9 cycles with no IDLE gap; results alternate lt/done_id=0 and eq/done_id=1.
5. Reset pulsed low in the 4th SHIFT cycle of a compare -> outputs immediately at reset values and no done for the aborted compare. After release, with both reqs high, requester 0 is granted first and the compare completes normally.
6. WIDTH=4, req1, a1=4'hF, b1=4'h0, with a1/b1 changed to 0 the cycle after grant -> done in cycle 5, res_gt=1 (latched operands used).

Source files
------------

// File: rtl/serial_cmp_scheduler.sv
// serial_cmp_scheduler
// Round-robin scheduler in front of one bit-serial unsigned magnitude comparator.
// Two requesters present parallel operand pairs. The winner's pair is latched at
// the grant edge and walked LSB-first through a compare accumulator, one bit per
// clock. The packed eq/gt/lt result is then published with the owner's ID.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   req0/req1      level compare requests
//   a0,b0 / a1,b1  operand pairs, sampled only at the grant edge
//   gnt0/gnt1      one-cycle pulse in the first SHIFT cycle of the granted compare
//   busy           high while a compare is shifting or completing
//   done           one-cycle pulse, result valid
//   done_id        requester that owns res_*
//   res_eq/gt/lt   registered unsigned compare result (one-hot, held until next done)
module serial_cmp_scheduler #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             res_eq,
  output logic             res_gt,
  output logic             res_lt
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sa, sb, sa_nxt, sb_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic             acc_eq, acc_gt, acc_lt;
  logic             acc_eq_nxt, acc_gt_nxt, acc_lt_nxt;
  logic             upd_eq, upd_gt, upd_lt;
  logic             last, last_nxt;
  logic             arb_go, win, last_bit;
  logic             gnt0_nxt, gnt1_nxt, busy_nxt, done_nxt, done_id_nxt;
  logic             res_eq_nxt, res_gt_nxt, res_lt_nxt;

  // Arbitration: only IDLE and DONE are arbitration points; on a tie the
  // requester that did not win last time is served.
  always_comb begin
    arb_go = 1'b0;
    win    = 1'b0;
    if ((state == IDLE || state == DONE) && (req0 || req1)) begin
      arb_go = 1'b1;
      if (req0 && req1) begin
        win = ~last;
      end else begin
        win = req1;
      end
    end else begin
      arb_go = 1'b0;
      win    = 1'b0;
    end
  end

  // Serial compare step: a differing bit overwrites the verdict, so the most
  // significant differing bit (processed last) decides the outcome.
  always_comb begin
    upd_eq = acc_eq;
    upd_gt = acc_gt;
    upd_lt = acc_lt;
    if (sa[0] && !sb[0]) begin
      upd_eq = 1'b0;
      upd_gt = 1'b1;
      upd_lt = 1'b0;
    end else if (!sa[0] && sb[0]) begin
      upd_eq = 1'b0;
      upd_gt = 1'b0;
      upd_lt = 1'b1;
    end else begin
      upd_eq = acc_eq;
      upd_gt = acc_gt;
      upd_lt = acc_lt;
    end
  end

  assign last_bit = (state == SHIFT) && (cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = arb_go ? SHIFT : IDLE;
      SHIFT:   state_nxt = last_bit ? DONE : SHIFT;
      DONE:    state_nxt = arb_go ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output/datapath logic: next values for every registered output and the
  // shift/accumulate datapath.
  always_comb begin
    sa_nxt      = sa;
    sb_nxt      = sb;
    cnt_nxt     = cnt;
    acc_eq_nxt  = acc_eq;
    acc_gt_nxt  = acc_gt;
    acc_lt_nxt  = acc_lt;
    last_nxt    = last;
    gnt0_nxt    = 1'b0;
    gnt1_nxt    = 1'b0;
    done_nxt    = 1'b0;
    busy_nxt    = (state_nxt != IDLE);
    done_id_nxt = done_id;
    res_eq_nxt  = res_eq;
    res_gt_nxt  = res_gt;
    res_lt_nxt  = res_lt;
    if (arb_go) begin
      sa_nxt     = win ? a1 : a0;
      sb_nxt     = win ? b1 : b0;
      cnt_nxt    = {CW{1'b0}};
      acc_eq_nxt = 1'b1;
      acc_gt_nxt = 1'b0;
      acc_lt_nxt = 1'b0;
      last_nxt   = win;
      gnt0_nxt   = ~win;
      gnt1_nxt   = win;
    end else if (state == SHIFT) begin
      sa_nxt     = sa >> 1;
      sb_nxt     = sb >> 1;
      cnt_nxt    = cnt + {{(CW-1){1'b0}}, 1'b1};
      acc_eq_nxt = upd_eq;
      acc_gt_nxt = upd_gt;
      acc_lt_nxt = upd_lt;
      if (last_bit) begin
        // last still names the owner of the in-flight compare
        res_eq_nxt  = upd_eq;
        res_gt_nxt  = upd_gt;
        res_lt_nxt  = upd_lt;
        done_id_nxt = last;
        done_nxt    = 1'b1;
      end else begin
        done_nxt    = 1'b0;
      end
    end else begin
      cnt_nxt = cnt;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sa      <= {WIDTH{1'b0}};
      sb      <= {WIDTH{1'b0}};
      cnt     <= {CW{1'b0}};
      acc_eq  <= 1'b1;
      acc_gt  <= 1'b0;
      acc_lt  <= 1'b0;
      last    <= 1'b1;
      gnt0    <= 1'b0;
      gnt1    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      done_id <= 1'b0;
      res_eq  <= 1'b1;
      res_gt  <= 1'b0;
      res_lt  <= 1'b0;
    end else begin
      sa      <= sa_nxt;
      sb      <= sb_nxt;
      cnt     <= cnt_nxt;
      acc_eq  <= acc_eq_nxt;
      acc_gt  <= acc_gt_nxt;
      acc_lt  <= acc_lt_nxt;
      last    <= last_nxt;
      gnt0    <= gnt0_nxt;
      gnt1    <= gnt1_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
      done_id <= done_id_nxt;
      res_eq  <= res_eq_nxt;
      res_gt  <= res_gt_nxt;
      res_lt  <= res_lt_nxt;
    end
  end

endmodule

// File: tb/tb_serial_cmp_scheduler.sv
// Testbench for serial_cmp_scheduler: a WIDTH=8 instance checked every cycle
// against a transaction-timeline reference model, plus a WIDTH=4 instance for
// the short-operand case.
module tb_serial_cmp_scheduler;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         gnt0, gnt1, busy, done, done_id, res_eq, res_gt, res_lt;

  logic         q_req0, q_req1;
  logic [3:0]   q_a0, q_b0, q_a1, q_b1;
  logic         q_gnt0, q_gnt1, q_busy, q_done, q_done_id, q_eq, q_gt, q_lt;

  serial_cmp_scheduler #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .req1(req1), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .res_eq(res_eq), .res_gt(res_gt), .res_lt(res_lt)
  );

  serial_cmp_scheduler #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset),
    .req0(q_req0), .a0(q_a0), .b0(q_b0), .req1(q_req1), .a1(q_a1), .b1(q_b1),
    .gnt0(q_gnt0), .gnt1(q_gnt1), .busy(q_busy), .done(q_done), .done_id(q_done_id),
    .res_eq(q_eq), .res_gt(q_gt), .res_lt(q_lt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tracks the latest grant (edge index, owner, operands) and
  // derives every expected output from elapsed edges and a plain comparison.
  int           edge_n;
  int           m_last;
  int           m_next_arb;
  bit           g_valid;
  int           g_edge;
  int           g_id;
  logic [W-1:0] g_a, g_b;
  bit           e_gnt0, e_gnt1, e_busy, e_done, e_done_id;
  logic [2:0]   e_res;

  function automatic logic [2:0] ucmp(input logic [W-1:0] a, input logic [W-1:0] b);
    if (a == b) return 3'b100;
    else if (a > b) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic model_reset();
    edge_n = 0; m_last = 1; m_next_arb = 0; g_valid = 0; g_edge = 0; g_id = 0;
    e_gnt0 = 0; e_gnt1 = 0; e_busy = 0; e_done = 0; e_done_id = 0; e_res = 3'b100;
  endtask

  // Predict the outputs for the cycle following the upcoming edge.
  task automatic model_edge();
    int w;
    e_gnt0 = 0; e_gnt1 = 0; e_done = 0;
    if (g_valid && edge_n == g_edge + W) begin
      e_done = 1; e_done_id = g_id[0]; e_res = ucmp(g_a, g_b);
    end
    if (edge_n >= m_next_arb && (req0 || req1)) begin
      if (req0 && req1) w = (m_last == 1) ? 0 : 1;
      else w = req1 ? 1 : 0;
      m_last = w; g_valid = 1; g_edge = edge_n; g_id = w;
      g_a = (w == 1) ? a1 : a0;
      g_b = (w == 1) ? b1 : b0;
      m_next_arb = edge_n + W + 1;
      e_gnt0 = (w == 0); e_gnt1 = (w == 1);
    end
    e_busy = g_valid && edge_n >= g_edge && edge_n <= g_edge + W;
    edge_n++;
  endtask

  task automatic check_all();
    check_value("gnt0", gnt0, e_gnt0);
    check_value("gnt1", gnt1, e_gnt1);
    check_value("busy", busy, e_busy);
    check_value("done", done, e_done);
    check_value("done_id", done_id, e_done_id);
    check_value("res", {res_eq, res_gt, res_lt}, e_res);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock edge.
  task automatic do_reset();
    #2 reset = 1'b0;
    #1;
    check_value("rst_busy", busy, 1'b0);
    check_value("rst_done", done, 1'b0);
    check_value("rst_gnt", {gnt0, gnt1}, 2'b00);
    check_value("rst_id", done_id, 1'b0);
    check_value("rst_res", {res_eq, res_gt, res_lt}, 3'b100);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
  endtask

  task automatic run_one(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] exp_res);
    req0 = !id; req1 = id;
    if (id) begin a1 = a; b1 = b; end else begin a0 = a; b0 = b; end
    tick();
    check_value("tp_gnt", {gnt0, gnt1}, id ? 2'b01 : 2'b10);
    req0 = 0; req1 = 0;
    repeat (W) tick();
    check_value("tp_done", done, 1'b1);
    check_value("tp_res", {res_eq, res_gt, res_lt}, exp_res);
    check_value("tp_id", done_id, id);
    tick();
  endtask

  initial begin
    reset = 1'b0;
    req0 = 0; req1 = 0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    q_req0 = 0; q_req1 = 0; q_a0 = '0; q_b0 = '0; q_a1 = '0; q_b1 = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_value("init_res", {res_eq, res_gt, res_lt}, 3'b100);
    check_value("init_busy", busy, 1'b0);
    reset = 1'b1;

    // Single compares: equal, MSB-decided greater, requester 1 less.
    run_one(1'b0, 8'h5A, 8'h5A, 3'b100);
    run_one(1'b0, 8'h80, 8'h7F, 3'b010);
    run_one(1'b1, 8'h01, 8'h02, 3'b001);

    // Both held: alternating grants back-to-back.
    a0 = 8'h10; b0 = 8'h20; a1 = 8'h30; b1 = 8'h30;
    req0 = 1; req1 = 1;
    repeat (4 * (W + 1)) tick();
    req0 = 0; req1 = 0;
    repeat (W + 2) tick();

    // Reset in the 4th SHIFT cycle of a compare.
    req0 = 1; a0 = 8'hC3; b0 = 8'h3C;
    tick();
    req0 = 0;
    repeat (3) tick();
    do_reset();
    req0 = 1; req1 = 1;
    tick();
    check_value("post_rst_gnt0", gnt0, 1'b1);
    req0 = 0; req1 = 0;
    repeat (W + 1) tick();

    // Narrow instance: operands change right after grant.
    q_req1 = 1; q_a1 = 4'hF; q_b1 = 4'h0;
    tick();
    check_value("w4_gnt1", q_gnt1, 1'b1);
    q_req1 = 0; q_a1 = 4'h0; q_b1 = 4'h0;
    repeat (3) tick();
    check_value("w4_early", q_done, 1'b0);
    tick();
    check_value("w4_done", q_done, 1'b1);
    check_value("w4_res", {q_eq, q_gt, q_lt}, 3'b010);
    check_value("w4_id", q_done_id, 1'b1);
    tick();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 2) != 0);
      a0 = W'($urandom); a1 = W'($urandom);
      b0 = ($urandom_range(0, 3) == 0) ? a0 : W'($urandom);
      b1 = ($urandom_range(0, 3) == 0) ? (a1 ^ W'(1 << $urandom_range(0, W - 1))) : W'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        tick();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
